// File: rtl/conf_int_sub_pkg.sv
// -----------------------------------------------------------------------------
// conf_int_sub_pkg
// Shared constants and types for the pipelined handshake subtractor.
//   OP_BITWIDTH_MIN / OP_BITWIDTH_MAX : supported operator widths
//   HALF_MAX                          : widest half-operand the payload carries
//   s1_payload_t                      : stage-1 -> stage-2 payload
// -----------------------------------------------------------------------------
package conf_int_sub_pkg;

  localparam int unsigned OP_BITWIDTH_MIN = 2;
  localparam int unsigned OP_BITWIDTH_MAX = 64;
  localparam int unsigned HALF_MAX        = OP_BITWIDTH_MAX / 2;

  // Stage-1 result: the finished low half, its borrow-out, and the untouched
  // high operand halves. Fields are sized for OP_BITWIDTH_MAX, and narrower
  // configurations use the low bits of each field.
  typedef struct packed {
    logic [HALF_MAX-1:0] diff_lo;
    logic                borrow;
    logic [HALF_MAX-1:0] a_hi;
    logic [HALF_MAX-1:0] b_hi;
  } s1_payload_t;

endpackage

// File: rtl/conf_int_sub_pipe_hs_if.sv
// -----------------------------------------------------------------------------
// conf_int_sub_pipe_hs_if
// Operand/result bus with valid/ready handshakes on both sides.
//   a, b, in_valid / in_ready        : operand pair and input handshake
//   d, borrow, out_valid / out_ready : result and output handshake
// Modports: master = traffic source/sink, slave = subtractor.
// -----------------------------------------------------------------------------
interface conf_int_sub_pipe_hs_if #(
  parameter int unsigned DATA_PATH_BITWIDTH = 16
);

  logic [DATA_PATH_BITWIDTH-1:0] a;
  logic [DATA_PATH_BITWIDTH-1:0] b;
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_PATH_BITWIDTH-1:0] d;
  logic                          borrow;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, d, borrow, out_valid
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, d, borrow, out_valid
  );

endinterface

// File: rtl/conf_int_sub_stage.sv
// -----------------------------------------------------------------------------
// conf_int_sub_stage
// One registered pipeline slice: W-bit subtractor with borrow-in/borrow-out,
// a pass-through payload, and a valid/ready handshake.
//   clk, rst           : clock, asynchronous active-low reset
//   valid_i / ready_o  : upstream handshake
//   x_i, y_i, bin_i    : minuend, subtrahend, borrow-in
//   pass_i / pass_o    : payload carried alongside unchanged
//   valid_o / ready_i  : downstream handshake
//   diff_o, bout_o     : registered difference and borrow-out
// The low APX bits are approximated as x XOR y. They produce no borrow, and
// bin_i enters at the lowest exact bit.
// -----------------------------------------------------------------------------
module conf_int_sub_stage
  import conf_int_sub_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned APX = 0,
  parameter int unsigned PW  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [W-1:0]  x_i,
  input  logic [W-1:0]  y_i,
  input  logic          bin_i,
  input  logic [PW-1:0] pass_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [W-1:0]  diff_o,
  output logic          bout_o,
  output logic [PW-1:0] pass_o
);

  localparam logic [W:0]   ONE      = (W+1)'(1);
  localparam logic [W:0]   MASK_EXT = (ONE << APX) - ONE;
  localparam logic [W-1:0] APX_MASK = MASK_EXT[W-1:0];

  logic [W:0]    sub;
  logic [W-1:0]  diff_d;
  logic          bout_d;
  logic          valid_q;
  logic [W-1:0]  diff_q;
  logic          bout_q;
  logic [PW-1:0] pass_q;

  // The approximated bits are zeroed before subtracting, so nothing borrows
  // out of them. The borrow-in is shifted up to the first exact bit. When the
  // whole slice is approximated, the borrow-in falls straight through to the
  // borrow-out.
  // NOTE: every variable in always_comb is fully assigned on every pass,
  // so no latch can be inferred.
  always_comb begin
    sub    = {1'b0, x_i & ~APX_MASK} - {1'b0, y_i & ~APX_MASK}
           - ({{W{1'b0}}, bin_i} << APX);
    diff_d = (sub[W-1:0] & ~APX_MASK) | ((x_i ^ y_i) & APX_MASK);
    bout_d = sub[W];
  end

  // The slice can load when it is empty or when its contents leave this edge.
  assign ready_o = !valid_q || ready_i;

  // NOTE: state registers use non-blocking assignments only. All of them,
  // data included, are reset so that the outputs read 0 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      pass_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
        pass_q <= pass_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign diff_o  = diff_q;
  assign bout_o  = bout_q;
  assign pass_o  = pass_q;

endmodule

// File: rtl/conf_int_sub_pipe_hs.sv
// -----------------------------------------------------------------------------
// conf_int_sub_pipe_hs
// Two-stage pipelined unsigned subtractor d = a - b with valid/ready
// handshakes and an optional approximation of the low APX_BITS bits.
//   clk : clock (rising edge)
//   rst : asynchronous active-low reset
//   bus : conf_int_sub_pipe_hs_if.slave (a, b, in_valid/in_ready,
//         d, borrow, out_valid/out_ready)
// Stage 1 subtracts the low half. Stage 2 subtracts the high half using the
// stage-1 borrow as its borrow-in.
// Build option: define CONF_INT_SUB_SAT_EN to saturate d to 0 on underflow.
// borrow is still reported when saturating.
// -----------------------------------------------------------------------------
module conf_int_sub_pipe_hs
  import conf_int_sub_pkg::*;
#(
  parameter int unsigned OP_BITWIDTH        = 16,
  parameter int unsigned DATA_PATH_BITWIDTH = 16,
  parameter int unsigned APX_BITS           = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  conf_int_sub_pipe_hs_if.slave bus
);

  localparam int unsigned LO_W   = OP_BITWIDTH / 2;
  localparam int unsigned HI_W   = OP_BITWIDTH - LO_W;
  // Split the approximated bits between the two halves.
  localparam int unsigned APX_LO = (APX_BITS > LO_W) ? LO_W : APX_BITS;
  localparam int unsigned APX_HI = (APX_BITS > LO_W) ? (APX_BITS - LO_W) : 0;

  logic              v1;
  logic              v2;
  logic              ready_s2;
  logic [LO_W-1:0]   lo_diff_s1;
  logic              lo_bout_s1;
  logic [2*HI_W-1:0] hi_ops_s1;
  s1_payload_t       s1;
  logic [HI_W-1:0]   hi_diff_s2;
  logic [LO_W-1:0]   lo_diff_s2;
  logic              borrow_s2;
  logic [OP_BITWIDTH-1:0] res_op;
  logic              unused_ok;

  conf_int_sub_stage #(
    .W   (LO_W),
    .APX (APX_LO),
    .PW  (2*HI_W)
  ) u_stage1 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (bus.in_valid),
    .ready_o (bus.in_ready),
    .x_i     (bus.a[LO_W-1:0]),
    .y_i     (bus.b[LO_W-1:0]),
    .bin_i   (1'b0),
    .pass_i  ({bus.a[OP_BITWIDTH-1:LO_W], bus.b[OP_BITWIDTH-1:LO_W]}),
    .valid_o (v1),
    .ready_i (ready_s2),
    .diff_o  (lo_diff_s1),
    .bout_o  (lo_bout_s1),
    .pass_o  (hi_ops_s1)
  );

  always_comb begin
    s1                  = '0;
    s1.diff_lo[LO_W-1:0] = lo_diff_s1;
    s1.borrow           = lo_bout_s1;
    s1.a_hi[HI_W-1:0]   = hi_ops_s1[2*HI_W-1:HI_W];
    s1.b_hi[HI_W-1:0]   = hi_ops_s1[HI_W-1:0];
  end

  conf_int_sub_stage #(
    .W   (HI_W),
    .APX (APX_HI),
    .PW  (LO_W)
  ) u_stage2 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (v1),
    .ready_o (ready_s2),
    .x_i     (s1.a_hi[HI_W-1:0]),
    .y_i     (s1.b_hi[HI_W-1:0]),
    .bin_i   (s1.borrow),
    .pass_i  (s1.diff_lo[LO_W-1:0]),
    .valid_o (v2),
    .ready_i (bus.out_ready),
    .diff_o  (hi_diff_s2),
    .bout_o  (borrow_s2),
    .pass_o  (lo_diff_s2)
  );

  // Saturation is a mask on registered values, so d stays stable while the
  // result is stalled.
  always_comb begin
`ifdef CONF_INT_SUB_SAT_EN
    res_op = borrow_s2 ? '0 : {hi_diff_s2, lo_diff_s2};
`else
    res_op = {hi_diff_s2, lo_diff_s2};
`endif
  end

  assign bus.d         = DATA_PATH_BITWIDTH'(res_op);
  assign bus.borrow    = borrow_s2;
  assign bus.out_valid = v2;

  // These bits are deliberately ignored: the operand bits above OP_BITWIDTH
  // and the payload bits beyond this configuration's half widths.
  assign unused_ok = ^{s1, bus.a, bus.b};

endmodule

// File: tb/tb_conf_int_sub_pipe_hs.sv
// -----------------------------------------------------------------------------
// tb_conf_int_sub_pipe_hs
// Directed bench for conf_int_sub_pipe_hs. The main instance is built with
// APX_BITS=0. A second instance with APX_BITS=4 shares the same stimulus.
// Expected values are hand-computed wrapped results. Saturation is applied
// on top of them when CONF_INT_SUB_SAT_EN is defined.
// -----------------------------------------------------------------------------
module tb_conf_int_sub_pipe_hs;

`ifdef CONF_INT_SUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  conf_int_sub_pipe_hs_if #(.DATA_PATH_BITWIDTH(16)) bus ();
  conf_int_sub_pipe_hs_if #(.DATA_PATH_BITWIDTH(16)) bus_apx ();

  assign bus_apx.a         = bus.a;
  assign bus_apx.b         = bus.b;
  assign bus_apx.in_valid  = bus.in_valid;
  assign bus_apx.out_ready = bus.out_ready;

  conf_int_sub_pipe_hs #(
    .OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(16), .APX_BITS(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  conf_int_sub_pipe_hs #(
    .OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(16), .APX_BITS(4)
  ) dut_apx (
    .clk (clk),
    .rst (rst),
    .bus (bus_apx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sat(input logic [15:0] d, input logic brw);
    return (SAT_EN && brw) ? 16'h0000 : d;
  endfunction

  // Drive one pair into an empty pipeline and check the latency, the result
  // and the drain. ed/eb are for the exact instance, ead/eab for APX_BITS=4.
  task automatic run_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] ed, input logic eb,
                            input logic [15:0] ead, input logic eab);
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, ".apx_in_ready"}, 32'(bus_apx.in_ready), 32'd1);
    tick;
    bus.in_valid = 1'b0;
    check({tag, ".lat1_out_valid"}, 32'(bus.out_valid), 32'd0);
    tick;
    check({tag, ".lat2_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".d"}, 32'(bus.d), 32'(sat(ed, eb)));
    check({tag, ".borrow"}, 32'(bus.borrow), 32'(eb));
    check({tag, ".apx_d"}, 32'(bus_apx.d), 32'(sat(ead, eab)));
    check({tag, ".apx_borrow"}, 32'(bus_apx.borrow), 32'(eab));
    tick;
    check({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Streaming vectors: a, b, wrapped d and borrow, all worked out by hand.
  logic [15:0] sa [8];
  logic [15:0] sb [8];
  logic [15:0] sd [8];
  logic        sbr[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int in_idx;
    int out_idx;
    int first_out;
    int last_out;
    logic seen;

    sa  = '{16'h0010, 16'h0001, 16'h1234, 16'hFFFF, 16'h0000, 16'h8000, 16'h00FF, 16'hABCD};
    sb  = '{16'h0001, 16'h0002, 16'h0234, 16'h0001, 16'h0001, 16'h7FFF, 16'h00FF, 16'h1111};
    sd  = '{16'h000F, 16'hFFFF, 16'h1000, 16'hFFFE, 16'hFFFF, 16'h0001, 16'h0000, 16'h9ABC};
    sbr = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0};

    // Reset state.
    rst           = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.d", 32'(bus.d), 32'd0);
    check("reset.borrow", 32'(bus.borrow), 32'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // The first vector is accepted on the first edge after the release.
    run_single("sub_5_3",       16'h0005, 16'h0003, 16'h0002, 1'b0, 16'h0006, 1'b0);
    run_single("sub_3_5",       16'h0003, 16'h0005, 16'hFFFE, 1'b1, 16'h0006, 1'b0);
    run_single("half_cross",    16'h0100, 16'h0001, 16'h00FF, 1'b0, 16'h0101, 1'b0);
    run_single("apx_13_5",      16'h0013, 16'h0005, 16'h000E, 1'b0, 16'h0016, 1'b0);
    run_single("apx_underflow", 16'h0003, 16'h0015, 16'hFFEE, 1'b1, 16'hFFF6, 1'b1);
    run_single("equal",         16'h1234, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Streaming with out_ready low for the first 4 cycles.
    in_idx    = 0;
    out_idx   = 0;
    first_out = -1;
    last_out  = -1;
    for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
      bus.out_ready = (cyc >= 4);
      bus.in_valid  = (in_idx < 8);
      if (in_idx < 8) begin
        bus.a = sa[in_idx];
        bus.b = sb[in_idx];
      end
      #1;
      if (cyc == 2) begin
        check("stream.in_ready_drop", 32'(bus.in_ready), 32'd0);
        check("stream.accepted_before_drop", 32'(in_idx), 32'd2);
      end
      if (cyc == 3) begin
        check("stream.stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stream.stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stream.stall_d", 32'(bus.d), 32'(sat(sd[0], sbr[0])));
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("stream.d[%0d]", out_idx), 32'(bus.d), 32'(sat(sd[out_idx], sbr[out_idx])));
        check($sformatf("stream.borrow[%0d]", out_idx), 32'(bus.borrow), 32'(sbr[out_idx]));
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        out_idx++;
      end
      if (bus.in_valid && bus.in_ready) in_idx++;
      tick;
    end
    bus.in_valid = 1'b0;
    check("stream.count", 32'(out_idx), 32'd8);
    check("stream.throughput_span", 32'(last_out - first_out), 32'd7);

    // Reset asserted with both stages full.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h0005;
    bus.b         = 16'h0001;
    tick;
    bus.a = 16'h0009;
    bus.b = 16'h0002;
    tick;
    bus.in_valid = 1'b0;
    check("rst_mid.full_out_valid", 32'(bus.out_valid), 32'd1);
    check("rst_mid.full_in_ready", 32'(bus.in_ready), 32'd0);
    #3;
    rst = 1'b0;
    #1;
    check("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid.d", 32'(bus.d), 32'd0);
    check("rst_mid.borrow", 32'(bus.borrow), 32'd0);
    check("rst_mid.in_ready", 32'(bus.in_ready), 32'd1);
    tick;
    tick;
    #3;
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    seen          = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_mid.no_spurious", 32'(seen), 32'd0);

    run_single("post_rst", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 16'h8001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/conf_int_sub_pipe_hs.md
CONF_INT_SUB_PIPE_HS -- requirements
Module: conf_int_sub_pipe_hs

Interface
REQ-001 SHALL have parameter OP_BITWIDTH, default 16: operator width; only the low OP_BITWIDTH bits of the operands are used.
REQ-002 SHALL have parameter DATA_PATH_BITWIDTH, default 16: port and register width, always >= OP_BITWIDTH.
REQ-003 SHALL have parameter APX_BITS, default 0: number of approximated LSBs, in the range 0..OP_BITWIDTH-1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port a, input, DATA_PATH_BITWIDTH bits: minuend.
REQ-007 SHALL have port b, input, DATA_PATH_BITWIDTH bits: subtrahend.
REQ-008 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: the input handshake.
REQ-009 SHALL have port d, output, DATA_PATH_BITWIDTH bits: difference.
REQ-010 SHALL have port borrow, output, 1 bit: unsigned underflow flag, set when a < b.
REQ-011 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the output handshake.

Function
REQ-012 SHALL accept an operand pair on any edge where in_valid && in_ready are both high.
REQ-013 SHALL deliver a result on any edge where out_valid && out_ready are both high.
REQ-014 SHALL have a 2-stage pipeline, giving a latency of exactly 2 cycles from acceptance to out_valid when there are no stalls.
REQ-015 SHALL, in stage 1, register the low half of the difference (bits [OP_BITWIDTH/2-1:0]), the borrow out of that half, and the high operand halves.
REQ-016 SHALL, in stage 2, compute the high half using the stage-1 borrow as borrow-in, then register d and borrow.
REQ-017 SHALL compute the result bits as follows:
- d[OP_BITWIDTH-1:0] = (a - b) mod 2^OP_BITWIDTH;
- d bits above OP_BITWIDTH-1 are 0;
- borrow = 1 exactly when a[OP_BITWIDTH-1:0] < b[OP_BITWIDTH-1:0].
REQ-018 SHALL, when APX_BITS > 0, apply the following approximation:
- d[APX_BITS-1:0] = a[APX_BITS-1:0] XOR b[APX_BITS-1:0];
- no borrow propagates out of those bits;
- borrow and the upper bits are computed from the remaining bits only.
REQ-019 SHALL use per-stage valid flags v1 and v2, with ready_s2 = !v2 || out_ready and in_ready = !v1 || ready_s2 (combinational).
REQ-020 SHALL move stage 1 into stage 2 when v1 && ready_s2; stage 1 is refilled in the same cycle if a new input is accepted.
REQ-021 SHALL hold d, borrow and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL sustain a throughput of 1 result per cycle when out_ready is held high.
REQ-023 SHALL, with both stages full and out_ready low, deassert in_ready; no data is lost or duplicated.
REQ-024 SHALL, on a simultaneous output handshake and input acceptance with both stages full, advance both stages and capture the new pair in stage 1.

Reset
REQ-025 SHALL, when rst is low, asynchronously clear v1, v2, d and borrow to 0.
REQ-026 SHALL hold out_valid at 0 during reset; in_ready is 1 immediately after reset.
REQ-027 SHALL discard any in-flight operations on reset asserted mid-operation, with no spurious out_valid after release.
REQ-028 SHALL be able to accept input on the first rising clk edge after rst deasserts.

Configuration
REQ-029 SHALL, when CONF_INT_SUB_SAT_EN is defined, replace d[OP_BITWIDTH-1:0] with 0 whenever borrow = 1 (unsigned saturation); borrow is still reported.
REQ-030 SHALL, when CONF_INT_SUB_SAT_EN is undefined, output the wrapped result of REQ-017/REQ-018 with no saturation logic present.

Structure
REQ-031 SHALL place the width-check constants and a stage-1 payload typedef (low difference, borrow, high a, high b) in the package conf_int_sub_pkg.
REQ-032 SHALL use one sub-module, conf_int_sub_stage, instantiated twice. It is a registered borrow-in/borrow-out half-width subtractor slice with valid/ready.

Verification (OP_BITWIDTH=16, DATA_PATH_BITWIDTH=16, APX_BITS=0 unless stated)
REQ-033 SHALL check a=5, b=3 with out_ready=1 -> d=0x0002, borrow=0, out_valid exactly 2 cycles after acceptance.
REQ-034 SHALL check a=3, b=5 -> without the macro, d=0xFFFE, borrow=1; with CONF_INT_SUB_SAT_EN, d=0x0000, borrow=1.
REQ-035 SHALL check a=0x0100, b=0x0001 (borrow crossing the halves) -> d=0x00FF, borrow=0.
REQ-036 SHALL check back-to-back streaming of 8 pairs with out_ready held low for 4 cycles:
- in_ready drops after 2 accepted pairs;
- all 8 results emerge in order and unchanged.
REQ-037 SHALL check APX_BITS=4 with a=0x0013, b=0x0005 -> d=0x0016, borrow=0.
REQ-038 SHALL check rst pulled low with both stages full -> out_valid=0 immediately, then no output until a new input is accepted after release.
